// File: rtl/ps2_pkg.sv
// PS/2 keyboard port shared types.
// Receiver states, register offsets, STATUS bit positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int NONEMPTY  = 0;
  localparam int FULL      = 1;
  localparam int OVF       = 2;
  localparam int PERR      = 3;
  localparam int COUNT_LSB = 4;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Pad sync, falling-edge detect, frame FSM, mid-frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       parity_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_prev_q;
  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;

  logic fall;
  logic din;
  logic timeout;
  logic frame_ok;
  logic at_stop;

  assign din      = dat_sync_q[1];
  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign timeout  = (state_q != IDLE) &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES));
  assign frame_ok = din & (^{shift_q, par_q});
  assign at_stop  = fall && (state_q == STOP);

  // Stop-bit verdict is combinational so the FIFO pushes on the next edge.
  assign byte_valid_o = at_stop & frame_ok;
  assign parity_err_o = at_stop & ~frame_ok;
  assign byte_data_o  = shift_q;

  // Two-flop synchronisers plus a delayed copy of the clock for edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Cycles since the last falling edge while a frame is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (fall || timeout || state_q == IDLE) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Frame FSM, one step per falling edge of the PS/2 clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!din) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          shift_q   <= {din, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_q <= PARITY;
        end
        PARITY: begin
          par_q   <= din;
          state_q <= STOP;
        end
        STOP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end else if (timeout) begin
      state_q <= IDLE;
      shift_q <= '0;
    end
  end

endmodule

// File: rtl/ps2_keyboard_port.sv
// Memory-mapped PS/2 keyboard port.
// Scancode FIFO with DATA/STATUS registers on the data bus.
module ps2_keyboard_port
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int ADDR_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [4:0]    count_q;
  logic [4:0]    count_d;
  logic          perr_q;
  logic          ovf_q;
  logic          irq_q;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_perr;

  logic       nonempty;
  logic       full;
  logic       pop;
  logic       push_ok;
  logic       ovf_set;
  logic       wr_status;
  logic [7:0] head;
  logic       unused_bits;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_data),
    .parity_err_o (rx_perr)
  );

  assign nonempty  = (count_q != 5'd0);
  assign full      = (count_q == 5'(FIFO_DEPTH));
  assign pop       = en && (memWrite == 4'b0000) &&
                     (addr[2] == REG_DATA) && nonempty;
  assign push_ok   = rx_valid && (!full || pop);
  assign ovf_set   = rx_valid && full && !pop;
  assign wr_status = en && memWrite[0] && (addr[2] == REG_STATUS);
  assign head      = nonempty ? mem_q[rd_ptr_q] : 8'h00;
  assign irq       = irq_q;

  assign unused_bits = ^{wdata[31:4], wdata[1:0],
                         addr[ADDR_W-1:3], addr[1:0]};

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q + 5'(push_ok) - 5'(pop);
  end

  // Scancode storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  // Pointers, occupancy, sticky flags and the interrupt line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      perr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      perr_q  <= (perr_q & ~(wr_status & wdata[2])) | rx_perr;
      ovf_q   <= (ovf_q & ~(wr_status & wdata[3])) | ovf_set;
      irq_q   <= (count_d != 5'd0);
    end
  end

  // Read mux; quiet whenever the bank is not selected.
  always_comb begin
    rdata = '0;
    if (en) begin
      if (addr[2] == REG_STATUS) begin
        rdata[COUNT_LSB +: 4] = count_q[3:0];
        rdata[PERR]           = perr_q;
        rdata[OVF]            = ovf_q;
        rdata[FULL]           = full;
        rdata[NONEMPTY]       = nonempty;
      end else begin
        rdata[8:0] = {nonempty, head};
      end
    end
  end

endmodule
